// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of DataMemory with youngest-match load forwarding
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_ready,
  output logic                     ld_data_valid,
  output logic [DW-1:0]            ld_data,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic [AW-1:0]            Mem_address,
  output logic                     Mem_read,
  output logic                     Mem_write,
  output logic [DW-1:0]            Write_data,
  input  logic [DW-1:0]            Read_Data
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [PW:0]   count_q, count_d;
  logic          ldv_q, ldv_d, hit_q, hit_d;
  logic [DW-1:0] fwd_q, fwd_d, hit_data;
  logic          full, hit, miss_acc, drain, st_acc;
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((PW+1)'(k) < count_q && addr_q[idx] == ld_addr) begin
        hit = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end
  assign full          = count_q == (PW+1)'(DEPTH);
  assign sb_empty      = count_q == '0;
  assign sb_count      = count_q;
  assign st_ready      = !full && !ld_valid;
  assign ld_ready      = hit || !full;
  assign st_acc        = st_valid && st_ready;
  assign miss_acc      = ld_valid && !hit && !full && !reset;
  assign drain         = !sb_empty && !miss_acc && !reset;
  assign Mem_read      = miss_acc;
  assign Mem_write     = drain;
  assign Mem_address   = miss_acc ? ld_addr : drain ? addr_q[head_q] : '0;
  assign Write_data    = drain ? data_q[head_q] : '0;
  assign ld_data_valid = ldv_q;
  // a miss returns DataMemory's registered read directly in the following cycle
  assign ld_data       = ldv_q ? (hit_q ? fwd_q : Read_Data) : '0;
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    addr_d[tail_q] = st_acc ? st_addr : addr_q[tail_q];
    data_d[tail_q] = st_acc ? st_data : data_q[tail_q];
    tail_d  = tail_q + PW'(st_acc);
    head_d  = head_q + PW'(drain);
    count_d = count_q + (PW+1)'(st_acc) - (PW+1)'(drain);
    ldv_d   = ld_valid && ld_ready;
    hit_d   = hit;
    fwd_d   = hit_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ldv_q   <= 1'b0;
      hit_q   <= 1'b0;
      fwd_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ldv_q   <= ldv_d;
      hit_q   <= hit_d;
      fwd_q   <= fwd_d;
    end
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed table, corner sequences and random traffic against a transparent-memory model
module tb_store_buffer;
  localparam int DEPTH = 4, AW = 32, DW = 32;
  logic clk = 1'b0, reset = 1'b1;
  logic st_valid = 1'b0, ld_valid = 1'b0;
  logic [AW-1:0] st_addr = '0, ld_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic st_ready, ld_ready, ld_data_valid, sb_empty, Mem_read, Mem_write;
  logic [DW-1:0] ld_data, Write_data;
  logic [DW-1:0] Read_Data = '0;
  logic [$clog2(DEPTH):0] sb_count;
  logic [AW-1:0] Mem_address;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ld_data_valid(ld_data_valid), .ld_data(ld_data), .sb_empty(sb_empty), .sb_count(sb_count),
    .Mem_address(Mem_address), .Mem_read(Mem_read), .Mem_write(Mem_write),
    .Write_data(Write_data), .Read_Data(Read_Data)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 0) ? 32'd4 : DW'(a + 2);
  endfunction

  // DataMemory stand-in: negedge write commit, registered read
  logic [DW-1:0] mem [16];
  logic [15:0] wr = '0;
  always @(negedge clk) if (Mem_write) begin
    mem[Mem_address[3:0]] <= Write_data;
    wr[Mem_address[3:0]] <= 1'b1;
  end
  always @(posedge clk) if (Mem_read)
    Read_Data <= wr[Mem_address[3:0]] ? mem[Mem_address[3:0]] : init_val(int'(Mem_address[3:0]));

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  logic [DW-1:0] mem_m [16];
  logic pend = 1'b0;
  logic [DW-1:0] pend_val = '0;
  logic e_rd, e_wr, e_st_acc, e_ld_acc;
  logic [DW-1:0] e_ld_val;
  int checks = 0, failures = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive_check(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                             input logic lv, input logic [AW-1:0] la);
    bit full, hit;
    logic [DW-1:0] hv;
    st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
    #2;
    full = q.size() == DEPTH;
    hit = 1'b0;
    hv = mem_m[la[3:0]];
    foreach (q[i]) if (q[i].a == la) begin hit = 1'b1; hv = q[i].d; end
    e_rd = lv && !hit && !full;
    e_wr = q.size() > 0 && !e_rd;
    e_st_acc = sv && !full && !lv;
    e_ld_acc = lv && (hit || !full);
    e_ld_val = hv;
    chk("sb_count", 64'(sb_count), 64'(q.size()));
    chk("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
    chk("st_ready", 64'(st_ready), 64'(!full && !lv));
    if (lv) chk("ld_ready", 64'(ld_ready), 64'(hit || !full));
    chk("Mem_read", 64'(Mem_read), 64'(e_rd));
    chk("Mem_write", 64'(Mem_write), 64'(e_wr));
    chk("Mem_address", 64'(Mem_address), 64'(e_rd ? la : e_wr ? q[0].a : '0));
    chk("Write_data", 64'(Write_data), 64'(e_wr ? q[0].d : '0));
    chk("ld_data_valid", 64'(ld_data_valid), 64'(pend));
    if (pend) chk("ld_data", 64'(ld_data), 64'(pend_val));
  endtask

  task automatic advance();
    @(posedge clk);
    if (e_wr) begin
      mem_m[q[0].a[3:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (e_st_acc) q.push_back('{st_addr, st_data});
    pend = e_ld_acc;
    pend_val = e_ld_val;
    #1;
  endtask

  task automatic step(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                      input logic lv, input logic [AW-1:0] la);
    drive_check(sv, sa, sd, lv, la);
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_Mem_read", 64'(Mem_read), 64'd0);
    chk("rst_Mem_write", 64'(Mem_write), 64'd0);
    @(posedge clk);
    q.delete();
    pend = 1'b0;
    #1;
    reset = 1'b0;
    chk("rst_ld_data_valid", 64'(ld_data_valid), 64'd0);
    chk("rst_ld_data", 64'(ld_data), 64'd0);
    chk("rst_sb_count", 64'(sb_count), 64'd0);
    chk("rst_sb_empty", 64'(sb_empty), 64'd1);
  endtask

  typedef struct {
    logic sv; logic [7:0] sa; logic [31:0] sd; logic lv; logic [7:0] la;
    logic e_str, e_ldr, e_rd, e_wr; logic [7:0] e_addr; logic [31:0] e_wd;
    logic e_ldv; logic [31:0] e_ldd; int e_cnt;
  } vec_t;

  initial begin
    vec_t tbl [7];
    tbl[0] = '{1'b0, 8'd0, 32'h0,  1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 32'h0,  1'b0, 32'h0,  0};
    tbl[1] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0,  1'b1, 32'h5,  0};
    tbl[2] = '{1'b1, 8'd2, 32'hAA, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0,  1'b0, 32'h0,  0};
    tbl[3] = '{1'b0, 8'd0, 32'h0,  1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 32'hAA, 1'b0, 32'h0,  1};
    tbl[4] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0,  1'b1, 32'hAA, 0};
    tbl[5] = '{1'b0, 8'd0, 32'h0,  1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 32'h0,  1'b0, 32'h0,  0};
    tbl[6] = '{1'b0, 8'd0, 32'h0,  1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0,  1'b1, 32'hAA, 0};
    for (int i = 0; i < 16; i++) mem_m[i] = init_val(i);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("init_sb_empty", 64'(sb_empty), 64'd1);
    chk("init_sb_count", 64'(sb_count), 64'd0);
    chk("init_ld_data_valid", 64'(ld_data_valid), 64'd0);
    foreach (tbl[i]) begin
      drive_check(tbl[i].sv, AW'(tbl[i].sa), tbl[i].sd, tbl[i].lv, AW'(tbl[i].la));
      chk("t_st_ready", 64'(st_ready), 64'(tbl[i].e_str));
      if (tbl[i].lv) chk("t_ld_ready", 64'(ld_ready), 64'(tbl[i].e_ldr));
      chk("t_Mem_read", 64'(Mem_read), 64'(tbl[i].e_rd));
      chk("t_Mem_write", 64'(Mem_write), 64'(tbl[i].e_wr));
      chk("t_Mem_address", 64'(Mem_address), 64'(tbl[i].e_addr));
      chk("t_Write_data", 64'(Write_data), 64'(tbl[i].e_wd));
      chk("t_ld_data_valid", 64'(ld_data_valid), 64'(tbl[i].e_ldv));
      if (tbl[i].e_ldv) chk("t_ld_data", 64'(ld_data), 64'(tbl[i].e_ldd));
      chk("t_sb_count", 64'(sb_count), 64'(tbl[i].e_cnt));
      advance();
    end
    // youngest match and in-order drain to the same word
    do_reset();
    step(1'b1, 5, 11, 1'b0, 0);
    step(1'b1, 5, 22, 1'b0, 0);
    step(1'b1, 5, 33, 1'b0, 0);
    step(1'b0, 0, 0, 1'b1, 5);
    drive_check(1'b0, 0, 0, 1'b0, 0);
    chk("youngest_ld_data", 64'(ld_data), 64'd33);
    advance();
    repeat (4) step(1'b0, 0, 0, 1'b0, 0);
    chk("mem5_final", 64'(mem[5]), 64'd33);
    // miss-load held while stores are offered: stores must wait, load returns memory[0]
    step(1'b1, 7, 32'h70, 1'b0, 0);
    repeat (3) step(1'b1, 6, 32'h60, 1'b1, 0);
    drive_check(1'b0, 0, 0, 1'b0, 0);
    chk("mem0_ld_data", 64'(ld_data), 64'd4);
    advance();
    repeat (6) step(1'b1, AW'($urandom_range(8, 15)), $urandom, 1'b0, 0);
    repeat (3) step(1'b0, 0, 0, 1'b0, 0);
    // reset while a drain is pending and a load is in flight
    step(1'b1, 1, 32'h77, 1'b0, 0);
    step(1'b1, 9, 32'h88, 1'b0, 0);
    wr[9] = 1'b0;
    do_reset();
    repeat (3) step(1'b0, 0, 0, 1'b0, 0);
    chk("no_drain_after_reset", 64'(wr[9]), 64'd0);
    step(1'b0, 0, 0, 1'b1, 4);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'b1 & ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 99) < 35), AW'($urandom_range(0, 7)));
    end
    repeat (6) step(1'b0, 0, 0, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
